cmp_rs: RTL and testbench

Reservation station for the branch comparator unit. Accepts decoded compare µops from dispatch and holds them until both operands are available, capturing operands by snooping the result broadcast bus. Drives the comparator's entry-data and ready vectors. An entry is retired the cycle after it is presented ready, because the comparator consumes every ready entry unconditionally.

---
 rtl/rv32i_types.sv | 65 ++++++
 rtl/prio_enc.sv | 23 ++
 rtl/cmp_rs.sv | 203 ++++++++++++++++++++
 tb/tb_cmp_rs.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// -----------------------------------------------------------------------------
// rv32i_types : shared types for the branch-compare reservation station.
//
// Contents:
//   TAG_W       ROB tag width
//   cmp_ops_t   comparator opcode (encoded like the RV32I branch funct3)
//   sal_t       one result-broadcast lane: rdy, tag, data
//   rs_t        per-entry view handed to the comparator: op, r1, r2, tag
//   rs_entry_t  full internal entry state, including the operand wakeup fields
//   entry_view  maps an internal entry to its comparator view (zero when empty)
// -----------------------------------------------------------------------------
package rv32i_types;

  localparam int TAG_W = 4;

  typedef enum logic [2:0] {
    cmp_beq  = 3'b000,
    cmp_bne  = 3'b001,
    cmp_blt  = 3'b100,
    cmp_bge  = 3'b101,
    cmp_bltu = 3'b110,
    cmp_bgeu = 3'b111
  } cmp_ops_t;

  typedef struct packed {
    logic             rdy;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } sal_t;

  typedef struct packed {
    cmp_ops_t         op;
    logic [31:0]      r1;
    logic [31:0]      r2;
    logic [TAG_W-1:0] tag;
  } rs_t;

  typedef struct packed {
    logic             valid;
    cmp_ops_t         op;
    logic [TAG_W-1:0] tag;
    logic [31:0]      r1;
    logic             r1_vld;
    logic [TAG_W-1:0] r1_tag;
    logic [31:0]      r2;
    logic             r2_vld;
    logic [TAG_W-1:0] r2_tag;
  } rs_entry_t;

  // Empty entries are presented as all-zero so the comparator never sees stale fields.
  function automatic rs_t entry_view(input rs_entry_t e);
    rs_t v;
    v = '0;
    if (e.valid) begin
      v.op  = e.op;
      v.r1  = e.r1;
      v.r2  = e.r2;
      v.tag = e.tag;
    end else begin
      v = '0;
    end
    return v;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// -----------------------------------------------------------------------------
// prio_enc : lowest-index priority selector.
//
// Ports:
//   i_req     [N-1:0]  request vector
//   o_onehot  [N-1:0]  one-hot of the lowest set request bit (zero when none)
// -----------------------------------------------------------------------------
module prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_onehot
);

  logic [N-1:0] w_neg;

  // Two's-complement isolate: x & -x keeps only the lowest set bit.
  always_comb begin
    w_neg    = ~i_req + {{(N-1){1'b0}}, 1'b1};
    o_onehot = i_req & w_neg;
  end

endmodule

// File: rtl/cmp_rs.sv
// -----------------------------------------------------------------------------
// cmp_rs : reservation station for the branch comparator unit.
//
// Holds dispatched compare uops until both operands are available, snooping
// the CDB_N result-broadcast lanes for wakeup. Ready entries are consumed by
// the comparator unconditionally and retire at the next edge.
//
// Ports:
//   clk, rst (async, active-low), flush (synchronous clear of all entries)
//   alloc_*       dispatch interface (valid, op, tag, two operands + vld + tag)
//   cdb[CDB_N]    result broadcast lanes
//   full, count   occupancy (from registered state)
//   data[SIZE]    per-entry op/r1/r2/tag, zero for empty entries
//   ready[SIZE]   entries presented to the comparator this cycle
//
// Build option: CMP_RS_SINGLE_ISSUE_EN -- when defined, only the lowest-index
// eligible entry is presented ready each cycle; otherwise all eligible are.
// -----------------------------------------------------------------------------
module cmp_rs #(
  parameter int SIZE  = 8,
  parameter int CDB_N = 4,
  parameter int TAG_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        alloc_valid,
  input  rv32i_types::cmp_ops_t       alloc_op,
  input  logic [TAG_W-1:0]            alloc_tag,
  input  logic [31:0]                 alloc_r1,
  input  logic                        alloc_r1_vld,
  input  logic [TAG_W-1:0]            alloc_r1_tag,
  input  logic [31:0]                 alloc_r2,
  input  logic                        alloc_r2_vld,
  input  logic [TAG_W-1:0]            alloc_r2_tag,
  input  rv32i_types::sal_t           cdb   [CDB_N],
  output logic                        full,
  output logic [$clog2(SIZE+1)-1:0]   count,
  output rv32i_types::rs_t            data  [SIZE],
  output logic [SIZE-1:0]             ready
);

  import rv32i_types::*;

  localparam int CNT_W = $clog2(SIZE+1);

  rs_entry_t        r_ent     [SIZE];
  rs_entry_t        w_ent_nxt [SIZE];
  rs_entry_t        w_new;
  logic [32:0]      w_wk1     [SIZE];
  logic [32:0]      w_wk2     [SIZE];
  logic [32:0]      w_a1;
  logic [32:0]      w_a2;
  logic [SIZE-1:0]  w_valid;
  logic [SIZE-1:0]  w_free;
  logic [SIZE-1:0]  w_elig;
  logic [SIZE-1:0]  w_alloc_oh;
  logic [SIZE-1:0]  w_issue;
  logic [CNT_W-1:0] w_count;
  logic             w_do_alloc;

  // Returns {hit, data} for the lowest-index ready lane carrying the given tag.
  function automatic logic [32:0] cdb_lookup(input logic [TAG_W-1:0] tag);
    logic [32:0] res;
    res = 33'd0;
    // Walk downward so the lowest matching lane is the last one written.
    for (int k = CDB_N - 1; k >= 0; k--) begin
      if (cdb[k].rdy && (cdb[k].tag == tag)) begin
        res = {1'b1, cdb[k].data};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Per-entry status bits taken from registered state only.
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      w_valid[i] = r_ent[i].valid;
      w_elig[i]  = r_ent[i].valid & r_ent[i].r1_vld & r_ent[i].r2_vld;
    end
    w_free = ~w_valid;
  end

  prio_enc #(.N(SIZE)) u_free_enc (
    .i_req    (w_free),
    .o_onehot (w_alloc_oh)
  );

`ifdef CMP_RS_SINGLE_ISSUE_EN
  prio_enc #(.N(SIZE)) u_issue_enc (
    .i_req    (w_elig),
    .o_onehot (w_issue)
  );
`else
  assign w_issue = w_elig;
`endif

  // Occupancy is the popcount of the valid bits.
  always_comb begin
    w_count = '0;
    for (int i = 0; i < SIZE; i++) begin
      w_count = w_count + CNT_W'(w_valid[i]);
    end
  end

  assign count      = w_count;
  assign full       = (w_count == CNT_W'(SIZE));
  assign ready      = w_issue;
  // Slots freed by this cycle's retirement are still counted, so full blocks them.
  assign w_do_alloc = alloc_valid & ~full & ~flush;

  // Comparator view of each entry.
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      data[i] = entry_view(r_ent[i]);
    end
  end

  // Wakeup lookups for the operand tags held in each entry.
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      w_wk1[i] = cdb_lookup(r_ent[i].r1_tag);
      w_wk2[i] = cdb_lookup(r_ent[i].r2_tag);
    end
  end

  // Entry image for an incoming uop, with same-cycle broadcast bypass on operands.
  always_comb begin
    w_new        = '0;
    w_a1         = cdb_lookup(alloc_r1_tag);
    w_a2         = cdb_lookup(alloc_r2_tag);
    w_new.valid  = 1'b1;
    w_new.op     = alloc_op;
    w_new.tag    = alloc_tag;
    w_new.r1_tag = alloc_r1_tag;
    w_new.r2_tag = alloc_r2_tag;
    if (alloc_r1_vld) begin
      w_new.r1     = alloc_r1;
      w_new.r1_vld = 1'b1;
    end else if (w_a1[32]) begin
      w_new.r1     = w_a1[31:0];
      w_new.r1_vld = 1'b1;
    end else begin
      w_new.r1     = 32'd0;
      w_new.r1_vld = 1'b0;
    end
    if (alloc_r2_vld) begin
      w_new.r2     = alloc_r2;
      w_new.r2_vld = 1'b1;
    end else if (w_a2[32]) begin
      w_new.r2     = w_a2[31:0];
      w_new.r2_vld = 1'b1;
    end else begin
      w_new.r2     = 32'd0;
      w_new.r2_vld = 1'b0;
    end
  end

  // Next-state per entry: flush, then retirement, wakeup of held entries, allocation into free ones.
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      w_ent_nxt[i] = r_ent[i];
      if (flush) begin
        w_ent_nxt[i] = '0;
      end else if (w_issue[i]) begin
        w_ent_nxt[i] = '0;
      end else if (r_ent[i].valid) begin
        if (!r_ent[i].r1_vld && w_wk1[i][32]) begin
          w_ent_nxt[i].r1     = w_wk1[i][31:0];
          w_ent_nxt[i].r1_vld = 1'b1;
        end else begin
          w_ent_nxt[i].r1_vld = r_ent[i].r1_vld;
        end
        if (!r_ent[i].r2_vld && w_wk2[i][32]) begin
          w_ent_nxt[i].r2     = w_wk2[i][31:0];
          w_ent_nxt[i].r2_vld = 1'b1;
        end else begin
          w_ent_nxt[i].r2_vld = r_ent[i].r2_vld;
        end
      end else if (w_do_alloc && w_alloc_oh[i]) begin
        w_ent_nxt[i] = w_new;
      end else begin
        w_ent_nxt[i] = r_ent[i];
      end
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SIZE; i++) begin
        r_ent[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        r_ent[i] <= w_ent_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_cmp_rs.sv
// -----------------------------------------------------------------------------
// tb_cmp_rs : self-checking bench for cmp_rs (directed scenarios + random
// traffic against a rule-level model). Honours CMP_RS_SINGLE_ISSUE_EN.
// -----------------------------------------------------------------------------
module tb_cmp_rs;
  import rv32i_types::*;

  localparam int SIZE  = 8;
  localparam int CDB_N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        alloc_valid;
  cmp_ops_t    alloc_op;
  logic [3:0]  alloc_tag, alloc_r1_tag, alloc_r2_tag;
  logic [31:0] alloc_r1, alloc_r2;
  logic        alloc_r1_vld, alloc_r2_vld;
  sal_t        cdb [CDB_N];
  logic        full;
  logic [3:0]  count;
  rs_t         data [SIZE];
  logic [SIZE-1:0] ready;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic        m_v   [SIZE];
  cmp_ops_t    m_op  [SIZE];
  logic [3:0]  m_tag [SIZE];
  logic [31:0] m_r1  [SIZE];
  logic [31:0] m_r2  [SIZE];
  logic        m_r1v [SIZE];
  logic        m_r2v [SIZE];
  logic [3:0]  m_r1t [SIZE];
  logic [3:0]  m_r2t [SIZE];

  cmp_ops_t ops [6] = '{cmp_beq, cmp_bne, cmp_blt, cmp_bge, cmp_bltu, cmp_bgeu};

  always #5 clk = ~clk;

  cmp_rs #(.SIZE(SIZE), .CDB_N(CDB_N), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .alloc_valid(alloc_valid),
    .alloc_op(alloc_op), .alloc_tag(alloc_tag),
    .alloc_r1(alloc_r1), .alloc_r1_vld(alloc_r1_vld), .alloc_r1_tag(alloc_r1_tag),
    .alloc_r2(alloc_r2), .alloc_r2_vld(alloc_r2_vld), .alloc_r2_tag(alloc_r2_tag),
    .cdb(cdb), .full(full), .count(count), .data(data), .ready(ready)
  );

  task automatic model_reset();
    for (int i = 0; i < SIZE; i++) begin
      m_v[i] = 1'b0; m_op[i] = cmp_beq; m_tag[i] = 4'h0;
      m_r1[i] = 32'd0; m_r2[i] = 32'd0; m_r1v[i] = 1'b0; m_r2v[i] = 1'b0;
      m_r1t[i] = 4'h0; m_r2t[i] = 4'h0;
    end
  endtask

  function automatic logic lane_hit(input logic [3:0] t, output logic [31:0] d);
    d = 32'd0;
    for (int k = 0; k < CDB_N; k++) begin
      if (cdb[k].rdy && cdb[k].tag == t) begin
        d = cdb[k].data;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [SIZE-1:0] exp_ready();
    logic [SIZE-1:0] r;
    r = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (m_v[i] && m_r1v[i] && m_r2v[i]) begin
`ifdef CMP_RS_SINGLE_ISSUE_EN
        if (r == '0) r[i] = 1'b1;
`else
        r[i] = 1'b1;
`endif
      end
    end
    return r;
  endfunction

  function automatic int exp_count();
    int c = 0;
    for (int i = 0; i < SIZE; i++) c += int'(m_v[i]);
    return c;
  endfunction

  // Apply one clock edge's worth of rules to the model, using current inputs.
  task automatic model_update();
    logic [SIZE-1:0] rdy;
    logic [31:0] d;
    int slot, cnt;
    rdy = exp_ready();
    cnt = exp_count();
    slot = -1;
    for (int i = 0; i < SIZE; i++) if (!m_v[i] && slot < 0) slot = i;
    if (flush) begin
      for (int i = 0; i < SIZE; i++) m_v[i] = 1'b0;
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        if (rdy[i]) m_v[i] = 1'b0;
        else if (m_v[i]) begin
          if (!m_r1v[i] && lane_hit(m_r1t[i], d)) begin m_r1[i] = d; m_r1v[i] = 1'b1; end
          if (!m_r2v[i] && lane_hit(m_r2t[i], d)) begin m_r2[i] = d; m_r2v[i] = 1'b1; end
        end
      end
      if (alloc_valid && cnt < SIZE) begin
        m_v[slot] = 1'b1; m_op[slot] = alloc_op; m_tag[slot] = alloc_tag;
        m_r1t[slot] = alloc_r1_tag; m_r2t[slot] = alloc_r2_tag;
        if (alloc_r1_vld) begin m_r1[slot] = alloc_r1; m_r1v[slot] = 1'b1; end
        else begin m_r1v[slot] = lane_hit(alloc_r1_tag, d); m_r1[slot] = d; end
        if (alloc_r2_vld) begin m_r2[slot] = alloc_r2; m_r2v[slot] = 1'b1; end
        else begin m_r2v[slot] = lane_hit(alloc_r2_tag, d); m_r2[slot] = d; end
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; alloc_valid = 1'b0; alloc_op = cmp_beq; alloc_tag = 4'h0;
    alloc_r1 = 32'd0; alloc_r1_vld = 1'b0; alloc_r1_tag = 4'h0;
    alloc_r2 = 32'd0; alloc_r2_vld = 1'b0; alloc_r2_tag = 4'h0;
    for (int k = 0; k < CDB_N; k++) cdb[k] = '0;
  endtask

  task automatic drive_alloc(input cmp_ops_t op, input logic [3:0] tag,
                             input logic [31:0] r1, input logic r1v, input logic [3:0] r1t,
                             input logic [31:0] r2, input logic r2v, input logic [3:0] r2t);
    alloc_valid = 1'b1; alloc_op = op; alloc_tag = tag;
    alloc_r1 = r1; alloc_r1_vld = r1v; alloc_r1_tag = r1t;
    alloc_r2 = r2; alloc_r2_vld = r2v; alloc_r2_tag = r2t;
  endtask

  task automatic test_reset();
    total++; if (ready !== 8'h00) begin bad++; $display("FAIL reset_ready: got %h exp 00", ready); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d exp 0", count); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b exp 0", full); end
    for (int i = 0; i < SIZE; i++) begin
      total++; if (data[i] !== '0) begin bad++; $display("FAIL reset_data%0d: got %h exp 0", i, data[i]); end
    end
  endtask

  task automatic test_basic();
    idle();
    drive_alloc(cmp_beq, 4'h9, 32'd5, 1'b1, 4'h0, 32'd5, 1'b1, 4'h0);
    step(); idle();
    total++; if (ready !== 8'h01) begin bad++; $display("FAIL basic_ready: got %h exp 01", ready); end
    total++; if (data[0].tag !== 4'h9) begin bad++; $display("FAIL basic_tag: got %h exp 9", data[0].tag); end
    total++; if (data[0].op !== cmp_beq || data[0].r1 !== 32'd5) begin bad++; $display("FAIL basic_fields: got %h", data[0]); end
    step();
    total++; if (ready !== 8'h00) begin bad++; $display("FAIL basic_retire_ready: got %h exp 00", ready); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL basic_retire_count: got %0d exp 0", count); end
  endtask

  task automatic test_wakeup();
    idle();
    drive_alloc(cmp_blt, 4'h5, 32'h10, 1'b1, 4'h0, 32'd0, 1'b0, 4'h3);
    step(); idle();
    total++; if (ready !== 8'h00 || count !== 4'd1) begin bad++; $display("FAIL wake_wait: got ready=%h count=%0d exp 00/1", ready, count); end
    cdb[2] = '{1'b0, 4'h3, 32'hFFFF_FFFF};
    step();
    total++; if (ready !== 8'h00) begin bad++; $display("FAIL wake_rdy0: got %h exp 00", ready); end
    cdb[2].rdy = 1'b1;
    step(); idle();
    total++; if (ready !== 8'h01) begin bad++; $display("FAIL wake_ready: got %h exp 01", ready); end
    total++; if (data[0].r2 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wake_r2: got %h exp ffffffff", data[0].r2); end
    step();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL wake_retire: got %0d exp 0", count); end
  endtask

  task automatic test_bypass();
    idle();
    drive_alloc(cmp_bne, 4'h2, 32'd1, 1'b1, 4'h0, 32'd0, 1'b0, 4'h7);
    cdb[0] = '{1'b1, 4'h7, 32'hAAAA_5555};
    step(); idle();
    total++; if (ready !== 8'h01) begin bad++; $display("FAIL bypass_ready: got %h exp 01", ready); end
    total++; if (data[0].r2 !== 32'hAAAA_5555) begin bad++; $display("FAIL bypass_r2: got %h exp aaaa5555", data[0].r2); end
    step();
    drive_alloc(cmp_bne, 4'h2, 32'd1, 1'b1, 4'h0, 32'd0, 1'b0, 4'h7);
    cdb[1] = '{1'b1, 4'h7, 32'h1111_1111};
    cdb[3] = '{1'b1, 4'h7, 32'h3333_3333};
    step(); idle();
    total++; if (data[0].r2 !== 32'h1111_1111) begin bad++; $display("FAIL bypass_lane_prio: got %h exp 11111111", data[0].r2); end
    step();
  endtask

  task automatic test_full();
    idle();
    for (int i = 0; i < SIZE; i++) begin
      drive_alloc(cmp_bge, 4'(i), 32'd0, 1'b0, 4'(8 + i), 32'(i), 1'b1, 4'h0);
      step();
    end
    idle();
    total++; if (count !== 4'd8 || full !== 1'b1) begin bad++; $display("FAIL full_fill: got count=%0d full=%b exp 8/1", count, full); end
    drive_alloc(cmp_bge, 4'hF, 32'd0, 1'b1, 4'h0, 32'd0, 1'b1, 4'h0);
    step(); idle();
    total++; if (count !== 4'd8 || data[7].tag !== 4'h7) begin bad++; $display("FAIL full_drop: got count=%0d tag7=%h exp 8/7", count, data[7].tag); end
    cdb[0] = '{1'b1, 4'hA, 32'h22};
    step(); idle();
    total++; if (ready !== 8'h04 || full !== 1'b1) begin bad++; $display("FAIL full_wake2: got ready=%h full=%b exp 04/1", ready, full); end
    drive_alloc(cmp_bltu, 4'hE, 32'd0, 1'b0, 4'h0, 32'd1, 1'b1, 4'h0);
    step();
    total++; if (count !== 4'd7 || full !== 1'b0 || data[2] !== '0) begin bad++; $display("FAIL full_same_cycle: got count=%0d full=%b d2=%h exp 7/0/0", count, full, data[2]); end
    step(); idle();
    total++; if (data[2].tag !== 4'hE || count !== 4'd8) begin bad++; $display("FAIL full_reuse: got tag=%h count=%0d exp e/8", data[2].tag, count); end
    flush = 1'b1;
    step(); idle();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL full_cleanup: got %0d exp 0", count); end
  endtask

  task automatic test_flush();
    idle();
    for (int i = 0; i < 5; i++) begin
      drive_alloc(cmp_beq, 4'(i), 32'd0, 1'b0, 4'h1, 32'd0, 1'b1, 4'h0);
      step();
    end
    idle();
    total++; if (count !== 4'd5) begin bad++; $display("FAIL flush_setup: got %0d exp 5", count); end
    drive_alloc(cmp_bne, 4'h8, 32'd1, 1'b1, 4'h0, 32'd2, 1'b1, 4'h0);
    flush = 1'b1;
    step(); idle();
    total++; if (count !== 4'd0 || ready !== 8'h00) begin bad++; $display("FAIL flush_clear: got count=%0d ready=%h exp 0/00", count, ready); end
    step();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL flush_alloc_drop: got %0d exp 0", count); end
    drive_alloc(cmp_bne, 4'h8, 32'd1, 1'b1, 4'h0, 32'd2, 1'b1, 4'h0);
    step(); idle();
    flush = 1'b1;
    #1;
    total++; if (ready !== 8'h01) begin bad++; $display("FAIL flush_ready_hold: got %h exp 01", ready); end
    step(); idle();
    total++; if (count !== 4'd0 || ready !== 8'h00) begin bad++; $display("FAIL flush_after: got count=%0d ready=%h exp 0/00", count, ready); end
  endtask

  task automatic test_issue();
    idle();
    drive_alloc(cmp_blt, 4'h0, 32'd0, 1'b0, 4'h6, 32'd9, 1'b1, 4'h0); step();
    drive_alloc(cmp_bge, 4'h1, 32'd0, 1'b0, 4'h6, 32'd0, 1'b0, 4'hB); step();
    drive_alloc(cmp_bgeu, 4'h2, 32'd4, 1'b1, 4'h0, 32'd0, 1'b0, 4'h6); step();
    idle();
    total++; if (count !== 4'd3 || ready !== 8'h00) begin bad++; $display("FAIL issue_setup: got count=%0d ready=%h exp 3/00", count, ready); end
    cdb[0] = '{1'b1, 4'h6, 32'h60};
    cdb[2] = '{1'b1, 4'hB, 32'hB0};
    step(); idle();
    total++; if (data[1].r1 !== 32'h60 || data[1].r2 !== 32'hB0) begin bad++; $display("FAIL issue_both_wake: got r1=%h r2=%h exp 60/b0", data[1].r1, data[1].r2); end
`ifdef CMP_RS_SINGLE_ISSUE_EN
    for (int i = 0; i < 3; i++) begin
      total++;
      if (ready !== 8'(1 << i) || count !== 4'(3 - i)) begin
        bad++; $display("FAIL issue_drain%0d: got ready=%h count=%0d exp %h/%0d", i, ready, count, 8'(1 << i), 3 - i);
      end
      step();
    end
`else
    total++; if (ready !== 8'h07) begin bad++; $display("FAIL issue_all: got %h exp 07", ready); end
    step();
`endif
    total++; if (count !== 4'd0 || ready !== 8'h00) begin bad++; $display("FAIL issue_done: got count=%0d ready=%h exp 0/00", count, ready); end
  endtask

  task automatic test_random();
    logic [SIZE-1:0] er;
    for (int c = 0; c < 400; c++) begin
      idle();
      if ($urandom_range(0, 9) < 6)
        drive_alloc(ops[$urandom_range(0, 5)], 4'($urandom_range(0, 15)),
                    $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      for (int k = 0; k < CDB_N; k++)
        cdb[k] = '{($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), $urandom};
      flush = ($urandom_range(0, 39) == 0);
      step();
      er = exp_ready();
      total++; if (ready !== er) begin bad++; $display("FAIL rnd_ready c%0d: got %h exp %h", c, ready, er); end
      total++; if (int'(count) != exp_count() || full !== (exp_count() == SIZE)) begin
        bad++; $display("FAIL rnd_count c%0d: got %0d/%b exp %0d", c, count, full, exp_count());
      end
      for (int i = 0; i < SIZE; i++) begin
        total++;
        if (!m_v[i]) begin
          if (data[i] !== '0) begin bad++; $display("FAIL rnd_empty c%0d e%0d: got %h exp 0", c, i, data[i]); end
        end else if (data[i].tag !== m_tag[i] || data[i].op !== m_op[i] ||
                     (m_r1v[i] && data[i].r1 !== m_r1[i]) || (m_r2v[i] && data[i].r2 !== m_r2[i])) begin
          bad++; $display("FAIL rnd_data c%0d e%0d: got %h exp op=%h tag=%h r1=%h r2=%h",
                          c, i, data[i], m_op[i], m_tag[i], m_r1[i], m_r2[i]);
        end
      end
    end
    idle();
    flush = 1'b1;
    step(); idle();
  endtask

  task automatic test_async_reset();
    idle();
    for (int i = 0; i < 3; i++) begin
      drive_alloc(cmp_bne, 4'(i), 32'd0, 1'b0, 4'h2, 32'd0, 1'b1, 4'h0);
      step();
    end
    idle();
    total++; if (count !== 4'd3) begin bad++; $display("FAIL areset_setup: got %0d exp 3", count); end
    #2;
    rst = 1'b0;
    #1;
    total++; if (count !== 4'd0 || full !== 1'b0 || ready !== 8'h00) begin
      bad++; $display("FAIL areset_outputs: got count=%0d full=%b ready=%h exp 0/0/00", count, full, ready);
    end
    for (int i = 0; i < SIZE; i++) begin
      total++; if (data[i] !== '0) begin bad++; $display("FAIL areset_data%0d: got %h exp 0", i, data[i]); end
    end
    model_reset();
    #1;
    rst = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_full();
    test_flush();
    test_issue();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
